// File: rtl/fma_exp_pkg.sv
// Shared types and constants for the FMA exponent pipeline.
// The subnormal exponent adjust in fma_exp_pipe is built only when
// FMA_EXP_SUBNORM_EN is defined.
package fma_exp_pkg;

  typedef enum logic {
    FMT_REDUCED = 1'b0,
    FMT_MAX     = 1'b1
  } fmt_e;

  // Default format geometry: binary64 as the max format, binary32 as the reduced one.
  localparam int unsigned NE_DEF    = 11;
  localparam int unsigned NF_DEF    = 52;
  localparam int unsigned BIAS_DEF  = 1023;
  localparam int unsigned NE1_DEF   = 8;
  localparam int unsigned NF1_DEF   = 23;
  localparam int unsigned BIAS1_DEF = 127;

  // Exponent bias of the selected format.
  function automatic int unsigned fmt_bias(input fmt_e f, input int unsigned bias_max,
                                           input int unsigned bias_red);
    return (f == FMT_MAX) ? bias_max : bias_red;
  endfunction

  // Fraction width F of the selected format.
  function automatic int unsigned fmt_frac(input fmt_e f, input int unsigned nf_max,
                                           input int unsigned nf_red);
    return (f == FMT_MAX) ? nf_max : nf_red;
  endfunction

  // Addend alignment offset: the addend starts F+2 places left of the product.
  function automatic int unsigned acnt_offset(input int unsigned nf);
    return nf + 2;
  endfunction

  // Beyond this shift the addend lies entirely below the sticky position.
  function automatic int unsigned kill_z_thresh(input int unsigned nf);
    return 3 * nf + 3;
  endfunction

endpackage

// File: rtl/fma_exp_calc.sv
// Second-stage exponent math: alignment count and kill flags from the
// product exponent and the addend exponent. Purely combinational.
module fma_exp_calc
  import fma_exp_pkg::*;
#(
  parameter int unsigned NE  = NE_DEF,
  parameter int unsigned NF  = NF_DEF,
  parameter int unsigned NF1 = NF1_DEF
) (
  input  fma_exp_pkg::fmt_e fmt,
  input  logic [NE+1:0]     pe,
  input  logic [NE-1:0]     ze,
  input  logic              xzero,
  input  logic              yzero,
  input  logic              zzero,
  output logic [NE+1:0]     acnt,
  output logic              kill_prod,
  output logic              kill_z
);

  localparam int unsigned W = NE + 2;

  localparam logic [W-1:0] OFF_MAX = W'(acnt_offset(fmt_frac(FMT_MAX, NF, NF1)));
  localparam logic [W-1:0] OFF_RED = W'(acnt_offset(fmt_frac(FMT_REDUCED, NF, NF1)));
  localparam logic [W-1:0] THR_MAX = W'(kill_z_thresh(fmt_frac(FMT_MAX, NF, NF1)));
  localparam logic [W-1:0] THR_RED = W'(kill_z_thresh(fmt_frac(FMT_REDUCED, NF, NF1)));

  logic [W-1:0] off;
  logic [W-1:0] thr;

  // Alignment shift (two's complement) and the two negligibility decisions.
  always_comb begin
    off       = (fmt == FMT_MAX) ? OFF_MAX : OFF_RED;
    thr       = (fmt == FMT_MAX) ? THR_MAX : THR_RED;
    acnt      = pe - {2'b00, ze} + off;
    // Negative shift: addend dominates, product only contributes sticky.
    kill_prod = xzero | yzero | (acnt[W-1] & ~zzero);
    // Positive shift past the datapath: addend only contributes sticky.
    kill_z    = zzero | (~acnt[W-1] & (acnt > thr));
  end

endmodule

// File: rtl/fma_exp_pipe.sv
// Two-stage FMA exponent pipeline: product exponent with format-selected
// bias in stage 1, addend alignment and kill flags in stage 2.
// Optional build macro: FMA_EXP_SUBNORM_EN (subnormal exponent fields use
// effective exponent 1).
module fma_exp_pipe
  import fma_exp_pkg::*;
#(
  parameter int unsigned NE    = NE_DEF,
  parameter int unsigned NF    = NF_DEF,
  parameter int unsigned BIAS  = BIAS_DEF,
  parameter int unsigned NE1   = NE1_DEF,
  parameter int unsigned NF1   = NF1_DEF,
  parameter int unsigned BIAS1 = BIAS1_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          Fmt,
  input  logic [NE-1:0] Xe,
  input  logic [NE-1:0] Ye,
  input  logic [NE-1:0] Ze,
  input  logic          XZero,
  input  logic          YZero,
  input  logic          ZZero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NE+1:0] Pe,
  output logic [NE+1:0] ACnt,
  output logic          KillProd,
  output logic          KillZ
);

  localparam int unsigned W = NE + 2;

  localparam logic [W-1:0]  BIAS_MAX_W = W'(fmt_bias(FMT_MAX, BIAS, BIAS1));
  localparam logic [W-1:0]  BIAS_RED_W = W'(fmt_bias(FMT_REDUCED, BIAS, BIAS1));
  // Reduced-format fields carry only NE1 meaningful (right-aligned) bits.
  localparam logic [NE-1:0] RED_MASK   = NE'((1 << NE1) - 1);

  // Handshake: a stage holds one entry while its valid is set. Stage 2 may
  // take a new entry when it is empty or its entry is popped this cycle
  // (out_valid & out_ready); stage 1 may take one when it is empty or moves
  // into stage 2. An input is accepted on in_valid & in_ready, and in_ready
  // is low during flush. Outputs are held unchanged while out_valid is set
  // and out_ready is low; empty stages are filled even while stalled.
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, accept;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  fmt_e          fmt_in;
  logic [NE-1:0] xe_eff, ye_eff, ze_eff;
  logic [W-1:0]  bias_sel;
  logic [W-1:0]  pe_next;

  assign fmt_in = fmt_e'(Fmt);

  // Effective exponents and stage-1 product exponent.
  always_comb begin
    xe_eff = (fmt_in == FMT_MAX) ? Xe : (Xe & RED_MASK);
    ye_eff = (fmt_in == FMT_MAX) ? Ye : (Ye & RED_MASK);
    ze_eff = (fmt_in == FMT_MAX) ? Ze : (Ze & RED_MASK);
`ifdef FMA_EXP_SUBNORM_EN
    // A non-zero operand with a zero exponent field is subnormal: its
    // significand is scaled as if the exponent were 1.
    if (!XZero && (xe_eff == '0)) xe_eff = NE'(1);
    if (!YZero && (ye_eff == '0)) ye_eff = NE'(1);
    if (!ZZero && (ze_eff == '0)) ze_eff = NE'(1);
`endif
    bias_sel = (fmt_in == FMT_MAX) ? BIAS_MAX_W : BIAS_RED_W;
    pe_next  = (XZero | YZero) ? '0 : ({2'b00, xe_eff} + {2'b00, ye_eff} - bias_sel);
  end

  fma_exp_pkg::fmt_e s1_fmt;
  logic [W-1:0]      s1_pe;
  logic [NE-1:0]     s1_ze;
  logic              s1_xz, s1_yz, s1_zz;

  logic [W-1:0]      acnt_next;
  logic              kp_next, kz_next;

  fma_exp_calc #(
    .NE  (NE),
    .NF  (NF),
    .NF1 (NF1)
  ) u_calc (
    .fmt       (s1_fmt),
    .pe        (s1_pe),
    .ze        (s1_ze),
    .xzero     (s1_xz),
    .yzero     (s1_yz),
    .zzero     (s1_zz),
    .acnt      (acnt_next),
    .kill_prod (kp_next),
    .kill_z    (kz_next)
  );

  // Stage valid bits: flush empties both stages at the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) s1_valid <= accept;
    end
  end

  // Stage-1 data: loads only when an operand set is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_fmt <= FMT_REDUCED;
      s1_pe  <= '0;
      s1_ze  <= '0;
      s1_xz  <= 1'b0;
      s1_yz  <= 1'b0;
      s1_zz  <= 1'b0;
    end else if (accept) begin
      s1_fmt <= fmt_in;
      s1_pe  <= pe_next;
      s1_ze  <= ze_eff;
      s1_xz  <= XZero;
      s1_yz  <= YZero;
      s1_zz  <= ZZero;
    end
  end

  // Stage-2 data: loads when a valid stage-1 entry moves forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Pe       <= '0;
      ACnt     <= '0;
      KillProd <= 1'b0;
      KillZ    <= 1'b0;
    end else if (s2_adv && s1_valid && !flush) begin
      Pe       <= s1_pe;
      ACnt     <= acnt_next;
      KillProd <= kp_next;
      KillZ    <= kz_next;
    end
  end

endmodule
